// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 1 bit/cycle shift-add multiply and restoring
// divide, with pipeline stall request and tagged single-cycle done pulse.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      dest_reg_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest_reg_out
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        op;
  logic [4:0]        tag;
  logic              neg;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;

  logic              accept, is_div, signed_a, signed_b, sa, sb;
  logic              div_zero, ovf, special, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;
  logic [XLEN:0]     mul_sum, trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  assign accept = start & ~flush & (state == IDLE);

  // Issue-time decode: magnitudes, result sign and the no-iteration special cases
  always_comb begin
    is_div   = funct3[2];
    signed_a = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    signed_b = is_div ? ~funct3[0] : (funct3 == 3'b001);
    sa       = signed_a & operand_a[XLEN-1];
    sb       = signed_b & operand_b[XLEN-1];
    a_mag    = sa ? (~operand_a + 1'b1) : operand_a;
    b_mag    = sb ? (~operand_b + 1'b1) : operand_b;
    neg_in   = (is_div & funct3[1]) ? sa : (sa ^ sb);
    div_zero = (operand_b == '0);
    ovf      = is_div & ~funct3[0] & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b);
    special  = is_div & (div_zero | ovf);
    // Overflowed DIV returns the dividend itself (0x8000_0000)
    if (div_zero) special_val = funct3[1] ? operand_a : '1;
    else          special_val = funct3[1] ? '0 : operand_a;
  end

  // Datapath: acc holds {hi, multiplier} for MUL, {remainder, quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    prod_fix = neg ? (~acc + 1'b1) : acc;
    quot_fix = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    if (op[2])              fix_val = op[1] ? rem_fix : quot_fix;
    else if (op[1:0] == '0) fix_val = prod_fix[XLEN-1:0];
    else                    fix_val = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (flush) state_nx = IDLE;
               else if (counter == '0) state_nx = FIXUP;
      FIXUP:   state_nx = flush ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == CALC) || (state == FIXUP);
    done      = (state == DONE);
    stall_req = busy | accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op           <= '0;
      tag          <= '0;
      neg          <= 1'b0;
      counter      <= '0;
      acc          <= '0;
      opnd         <= '0;
      result       <= '0;
      dest_reg_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op      <= funct3;
          tag     <= dest_reg_in;
          neg     <= neg_in;
          counter <= CW'(XLEN - 1);
          if (special) begin
            result       <= special_val;
            dest_reg_out <= dest_reg_in;
          end else if (is_div) begin
            acc  <= {{XLEN{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            acc  <= {{XLEN{1'b0}}, b_mag};
            opnd <= a_mag;
          end
        end
        CALC: begin
          counter <= counter - 1'b1;
          if (!op[2])         acc <= {mul_sum, acc[XLEN-1:1]};
          else if (!trial[XLEN]) acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          else                acc <= {acc[2*XLEN-2:0], 1'b0};
        end
        // Tag is copied to the output only here so a flushed op leaves the prior pair intact
        FIXUP: if (!flush) begin
          result       <= fix_val;
          dest_reg_out <= tag;
        end
        default: ;
      endcase
    end
  end

endmodule
